seq_det_sched: RTL

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

---
 rtl/seq_det_sched.sv | 78 +++++++
 1 files changed

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin frame scheduler that feeds a serial 4-bit pattern-match counter.
// Each accepted 16-bit frame is shifted MSB first and overlapping pattern hits are counted.
module seq_det_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cfg_pattern,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [15:0] req0_data,
    input  logic [15:0] req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        res_valid,
    output logic        res_id,
    output logic [4:0]  res_count,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_n;
    logic last, take, pick1, cur_id, hit;
    logic [15:0] frame;
    logic [3:0] pat, win, win_n, nbit;
    logic [4:0] cnt, cnt_n;
    // With both requesters valid, the one not served last wins.
    assign pick1 = req1_valid & (~req0_valid | ~last);
    assign take = (state == IDLE) & ~rst & (req0_valid | req1_valid);
    assign req0_ready = take & ~pick1;
    assign req1_ready = take & pick1;
    assign win_n = {win[2:0], frame[15]};
    // nbit counts bits already shifted, so nbit >= 3 means this is bit 4 or later.
    assign hit = (nbit >= 4'd3) & (win_n == pat);
    assign cnt_n = cnt + {4'd0, hit};
    assign res_valid = state == DONE;
    assign busy = state != IDLE;
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = take ? SHIFT : IDLE;
            SHIFT:   state_n = (nbit == 4'd15) ? DONE : SHIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cur_id    <= 1'b0;
            frame     <= '0;
            pat       <= '0;
            win       <= '0;
            nbit      <= '0;
            cnt       <= '0;
            res_id    <= 1'b0;
            res_count <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                frame  <= pick1 ? req1_data : req0_data;
                cur_id <= pick1;
                pat    <= cfg_pattern;
                last   <= pick1;
                win    <= '0;
                nbit   <= '0;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                frame <= {frame[14:0], 1'b0};
                win   <= win_n;
                nbit  <= nbit + 4'd1;
                cnt   <= cnt_n;
                if (nbit == 4'd15) begin
                    res_id    <= cur_id;
                    res_count <= cnt_n;
                end
            end
        end
    end
endmodule
